// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: opcodes, one-hot T-states and control-word bit positions.
// The control-word indices are also meant for the datapath top level.
package sap1_pkg;

  localparam int OPCODE_W = 4;
  localparam logic [OPCODE_W-1:0] OP_LDA = 4'b0000;
  localparam logic [OPCODE_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'b0010;
  localparam logic [OPCODE_W-1:0] OP_OUT = 4'b1110;
  localparam logic [OPCODE_W-1:0] OP_HLT = 4'b1111;

  localparam int T_W = 6;
  localparam logic [T_W-1:0] T1 = 6'b000001;
  localparam logic [T_W-1:0] T2 = 6'b000010;
  localparam logic [T_W-1:0] T3 = 6'b000100;
  localparam logic [T_W-1:0] T4 = 6'b001000;
  localparam logic [T_W-1:0] T5 = 6'b010000;
  localparam logic [T_W-1:0] T6 = 6'b100000;

  localparam int CW_CP = 0;
  localparam int CW_EP = 1;
  localparam int CW_LM = 2;
  localparam int CW_CE = 3;
  localparam int CW_LI = 4;
  localparam int CW_EI = 5;
  localparam int CW_LA = 6;
  localparam int CW_EA = 7;
  localparam int CW_SU = 8;
  localparam int CW_EU = 9;
  localparam int CW_LB = 10;
  localparam int CW_LO = 11;
  localparam int CW_W  = 12;

  typedef logic [CW_W-1:0] ctrl_word_t;

  typedef enum logic [2:0] {
    OPC_LDA,
    OPC_ADD,
    OPC_SUB,
    OPC_OUT,
    OPC_HLT,
    OPC_NOP
  } op_class_e;

endpackage

// File: rtl/sap1_ring_counter.sv
// Six-bit one-hot T-state ring: rotates left each edge, can hold (halt) or
// jump back to T1 (early instruction end). Reset always wins.
module sap1_ring_counter
  import sap1_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           hold_i,
  input  logic           load_t1_i,
  output logic [T_W-1:0] ring_o
);

  logic [T_W-1:0] ring_q;
  logic [T_W-1:0] ring_d;
  logic [T_W-1:0] ring_rot;

  generate
    for (genvar gi = 0; gi < T_W; gi++) begin : g_rot
      assign ring_rot[gi] = ring_q[(gi + T_W - 1) % T_W];
    end
  endgenerate

  always_comb begin
    ring_d = ring_q;
    if (hold_i) begin
      ring_d = ring_q;
    end else if (load_t1_i) begin
      ring_d = T1;
    end else begin
      ring_d = ring_rot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ring_q <= T1;
    end else begin
      ring_q <= ring_d;
    end
  end

  assign ring_o = ring_q;

endmodule

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 control unit: T-state ring plus a combinational decode of T-state and
// opcode into the control word. HLT freezes the ring until reset.
module sap1_controller_sequencer
  import sap1_pkg::*;
#(
  parameter int OPW      = 4,
  parameter bit FAST_NOP = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  output logic           Cp,
  output logic           Ep,
  output logic           Lm,
  output logic           Ce,
  output logic           Li,
  output logic           Ei,
  output logic           La,
  output logic           Ea,
  output logic           Su,
  output logic           Eu,
  output logic           Lb,
  output logic           Lo,
  output logic           hlt,
  output logic [T_W-1:0] t_state
);

  logic [T_W-1:0] ring;
  logic           halted_q;
  logic           halted_d;
  logic           halt_now;
  logic           ring_hold;
  logic           ring_load_t1;
  op_class_e      op_class;
  ctrl_word_t     cw;
  logic           hlt_c;

  always_comb begin
    op_class = OPC_NOP;
    if (opcode == OPW'(OP_LDA)) begin
      op_class = OPC_LDA;
    end else if (opcode == OPW'(OP_ADD)) begin
      op_class = OPC_ADD;
    end else if (opcode == OPW'(OP_SUB)) begin
      op_class = OPC_SUB;
    end else if (opcode == OPW'(OP_OUT)) begin
      op_class = OPC_OUT;
    end else if (opcode == OPW'(OP_HLT)) begin
      op_class = OPC_HLT;
    end
  end

  // HLT is recognised in T4; the ring holds there from that edge onward.
  assign halt_now  = !halted_q && (ring == T4) && (op_class == OPC_HLT);
  assign halted_d  = halted_q | halt_now;
  assign ring_hold = halted_q | halt_now;

  always_comb begin
    ring_load_t1 = 1'b0;
    if (FAST_NOP && !halted_q) begin
      if ((ring == T4) && ((op_class == OPC_OUT) || (op_class == OPC_NOP))) begin
        ring_load_t1 = 1'b1;
      end else if ((ring == T5) && (op_class == OPC_LDA)) begin
        ring_load_t1 = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  sap1_ring_counter u_ring (
    .clk       (clk),
    .rst       (rst),
    .hold_i    (ring_hold),
    .load_t1_i (ring_load_t1),
    .ring_o    (ring)
  );

  always_comb begin
    cw    = '0;
    hlt_c = 1'b0;
    if (rst) begin
      cw    = '0;
      hlt_c = 1'b0;
    end else if (halted_q) begin
      hlt_c = 1'b1;
    end else begin
      case (ring)
        T1: begin
          cw[CW_EP] = 1'b1;
          cw[CW_LM] = 1'b1;
        end
        T2: cw[CW_CP] = 1'b1;
        T3: begin
          cw[CW_CE] = 1'b1;
          cw[CW_LI] = 1'b1;
        end
        T4: begin
          case (op_class)
            OPC_LDA, OPC_ADD, OPC_SUB: begin
              cw[CW_EI] = 1'b1;
              cw[CW_LM] = 1'b1;
            end
            OPC_OUT: begin
              cw[CW_EA] = 1'b1;
              cw[CW_LO] = 1'b1;
            end
            OPC_HLT: hlt_c = 1'b1;
            default: ;
          endcase
        end
        T5: begin
          case (op_class)
            OPC_LDA: begin
              cw[CW_CE] = 1'b1;
              cw[CW_LA] = 1'b1;
            end
            OPC_ADD, OPC_SUB: begin
              cw[CW_CE] = 1'b1;
              cw[CW_LB] = 1'b1;
            end
            default: ;
          endcase
        end
        T6: begin
          // Su is only ever raised together with Eu in SUB's final cycle.
          case (op_class)
            OPC_ADD: begin
              cw[CW_EU] = 1'b1;
              cw[CW_LA] = 1'b1;
            end
            OPC_SUB: begin
              cw[CW_EU] = 1'b1;
              cw[CW_LA] = 1'b1;
              cw[CW_SU] = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign Cp      = cw[CW_CP];
  assign Ep      = cw[CW_EP];
  assign Lm      = cw[CW_LM];
  assign Ce      = cw[CW_CE];
  assign Li      = cw[CW_LI];
  assign Ei      = cw[CW_EI];
  assign La      = cw[CW_LA];
  assign Ea      = cw[CW_EA];
  assign Su      = cw[CW_SU];
  assign Eu      = cw[CW_EU];
  assign Lb      = cw[CW_LB];
  assign Lo      = cw[CW_LO];
  assign hlt     = hlt_c;
  assign t_state = ring;

endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// Scoreboard bench: stimulus pushes expected {t_state, controls, hlt} per cycle,
// a negedge monitor pops and compares. Two instances cover FAST_NOP=0 and 1.
module tb_sap1_controller_sequencer;

  localparam logic [11:0] CP = 12'h800, EP = 12'h400, LM = 12'h200, CE = 12'h100;
  localparam logic [11:0] LI = 12'h080, EI = 12'h040, LA = 12'h020, EA = 12'h010;
  localparam logic [11:0] SU = 12'h008, EU = 12'h004, LB = 12'h002, LO = 12'h001;

  typedef struct {
    bit          sel;
    logic [5:0]  t;
    logic [11:0] cw;
    logic        h;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0 = 1'b1, rst1 = 1'b1;
  logic [3:0] op0 = 4'h0, op1 = 4'h0;

  logic Cp0, Ep0, Lm0, Ce0, Li0, Ei0, La0, Ea0, Su0, Eu0, Lb0, Lo0, h0;
  logic Cp1, Ep1, Lm1, Ce1, Li1, Ei1, La1, Ea1, Su1, Eu1, Lb1, Lo1, h1;
  logic [5:0] t0, t1;

  sap1_controller_sequencer #(.OPW(4), .FAST_NOP(1'b0)) dut0 (
    .clk(clk), .rst(rst0), .opcode(op0),
    .Cp(Cp0), .Ep(Ep0), .Lm(Lm0), .Ce(Ce0), .Li(Li0), .Ei(Ei0), .La(La0),
    .Ea(Ea0), .Su(Su0), .Eu(Eu0), .Lb(Lb0), .Lo(Lo0), .hlt(h0), .t_state(t0)
  );

  sap1_controller_sequencer #(.OPW(4), .FAST_NOP(1'b1)) dut1 (
    .clk(clk), .rst(rst1), .opcode(op1),
    .Cp(Cp1), .Ep(Ep1), .Lm(Lm1), .Ce(Ce1), .Li(Li1), .Ei(Ei1), .La(La1),
    .Ea(Ea1), .Su(Su1), .Eu(Eu1), .Lb(Lb1), .Lo(Lo1), .hlt(h1), .t_state(t1)
  );

  wire [11:0] cw0 = {Cp0, Ep0, Lm0, Ce0, Li0, Ei0, La0, Ea0, Su0, Eu0, Lb0, Lo0};
  wire [11:0] cw1 = {Cp1, Ep1, Lm1, Ce1, Li1, Ei1, La1, Ea1, Su1, Eu1, Lb1, Lo1};

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic step(input bit sel, input logic r, input logic [3:0] op,
                      input logic [5:0] et, input logic [11:0] ecw, input logic eh,
                      input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    if (sel) begin
      rst1 = r; op1 = op;
    end else begin
      rst0 = r; op0 = op;
    end
    e.sel = sel; e.t = et; e.cw = ecw; e.h = eh; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic fetch(input bit sel, input logic [3:0] op);
    step(sel, 1'b0, op, 6'h01, EP | LM, 1'b0, "t1_fetch");
    step(sel, 1'b0, op, 6'h02, CP,      1'b0, "t2_fetch");
    step(sel, 1'b0, op, 6'h04, CE | LI, 1'b0, "t3_fetch");
  endtask

  // Independent reference for a 6-step (FAST_NOP=0) non-HLT instruction.
  function automatic logic [11:0] model(input logic [3:0] op, input int p);
    logic [11:0] r;
    r = '0;
    case (p)
      0: r = EP | LM;
      1: r = CP;
      2: r = CE | LI;
      3: if (op == 4'h0 || op == 4'h1 || op == 4'h2) r = EI | LM;
         else if (op == 4'hE) r = EA | LO;
      4: if (op == 4'h0) r = CE | LA;
         else if (op == 4'h1 || op == 4'h2) r = CE | LB;
      5: if (op == 4'h1) r = EU | LA;
         else if (op == 4'h2) r = EU | LA | SU;
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic [11:0] acw;
    logic [5:0]  at;
    logic        ah;
    if ($countones({Ep0, Ce0, Ei0, Ea0, Eu0}) > 1 && !rst0) begin
      n_errors++;
      $display("FAIL bus_excl dut0 got drivers=%b required at most one", {Ep0, Ce0, Ei0, Ea0, Eu0});
    end
    if ($countones({Ep1, Ce1, Ei1, Ea1, Eu1}) > 1 && !rst1) begin
      n_errors++;
      $display("FAIL bus_excl dut1 got drivers=%b required at most one", {Ep1, Ce1, Ei1, Ea1, Eu1});
    end
    n_checks += 2;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      acw = e.sel ? cw1 : cw0;
      at  = e.sel ? t1 : t0;
      ah  = e.sel ? h1 : h0;
      n_checks++;
      if (acw !== e.cw || at !== e.t || ah !== e.h) begin
        n_errors++;
        $display("FAIL %s dut%0d got t=%h cw=%h hlt=%b required t=%h cw=%h hlt=%b",
                 e.name, e.sel, at, acw, ah, e.t, e.cw, e.h);
      end else begin
        $display("ok   %s dut%0d t=%h cw=%h hlt=%b", e.name, e.sel, at, acw, ah);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] rop;
    int         p;
    repeat (2) @(posedge clk);

    // FAST_NOP=0 instance
    step(0, 1'b1, 4'h1, 6'h01, 12'h000, 1'b0, "reset_state");
    fetch(0, 4'h1);
    step(0, 1'b0, 4'h1, 6'h08, EI | LM, 1'b0, "add_t4");
    step(0, 1'b0, 4'h1, 6'h10, CE | LB, 1'b0, "add_t5");
    step(0, 1'b0, 4'h1, 6'h20, EU | LA, 1'b0, "add_t6");
    fetch(0, 4'h2);
    step(0, 1'b0, 4'h2, 6'h08, EI | LM, 1'b0, "sub_t4");
    step(0, 1'b0, 4'h2, 6'h10, CE | LB, 1'b0, "sub_t5");
    step(0, 1'b0, 4'h2, 6'h20, EU | LA | SU, 1'b0, "sub_t6");
    fetch(0, 4'h0);
    step(0, 1'b0, 4'h0, 6'h08, EI | LM, 1'b0, "lda_t4");
    step(0, 1'b0, 4'h0, 6'h10, CE | LA, 1'b0, "lda_t5");
    step(0, 1'b0, 4'h0, 6'h20, 12'h000, 1'b0, "lda_t6");
    fetch(0, 4'hE);
    step(0, 1'b0, 4'hE, 6'h08, EA | LO, 1'b0, "out_t4");
    step(0, 1'b0, 4'hE, 6'h10, 12'h000, 1'b0, "out_t5");
    step(0, 1'b0, 4'hE, 6'h20, 12'h000, 1'b0, "out_t6");
    fetch(0, 4'hF);
    step(0, 1'b0, 4'hF, 6'h08, 12'h000, 1'b1, "hlt_t4");
    for (int i = 0; i < 20; i++) begin
      rop = 4'($urandom_range(0, 15));
      step(0, 1'b0, rop, 6'h08, 12'h000, 1'b1, "halted_hold");
    end
    step(0, 1'b1, 4'h1, 6'h08, 12'h000, 1'b0, "halt_rst");
    fetch(0, 4'h1);
    step(0, 1'b0, 4'h1, 6'h08, EI | LM, 1'b0, "post_halt_t4");
    step(0, 1'b0, 4'h1, 6'h10, CE | LB, 1'b0, "post_halt_t5");
    step(0, 1'b0, 4'h1, 6'h20, EU | LA, 1'b0, "post_halt_t6");
    fetch(0, 4'h1);
    step(0, 1'b0, 4'h1, 6'h08, EI | LM, 1'b0, "add_t4");
    step(0, 1'b1, 4'h1, 6'h10, 12'h000, 1'b0, "rst_in_t5");
    step(0, 1'b0, 4'h1, 6'h01, EP | LM, 1'b0, "after_rst_t1");
    step(0, 1'b0, 4'h1, 6'h02, CP,      1'b0, "after_rst_t2");
    step(0, 1'b0, 4'h1, 6'h04, CE | LI, 1'b0, "after_rst_t3");
    step(0, 1'b0, 4'h1, 6'h08, EI | LM, 1'b0, "after_rst_t4");
    step(0, 1'b0, 4'h1, 6'h10, CE | LB, 1'b0, "after_rst_t5");
    step(0, 1'b0, 4'h1, 6'h20, EU | LA, 1'b0, "after_rst_t6");

    p = 0;
    for (int i = 0; i < 1000; i++) begin
      rop = 4'($urandom_range(0, 14));
      step(0, 1'b0, rop, 6'(1 << p), model(rop, p), 1'b0, "random");
      p = (p + 1) % 6;
    end

    // FAST_NOP=1 instance (held in reset until now)
    step(1, 1'b1, 4'hE, 6'h01, 12'h000, 1'b0, "fast_reset");
    fetch(1, 4'hE);
    step(1, 1'b0, 4'hE, 6'h08, EA | LO, 1'b0, "fast_out_t4");
    fetch(1, 4'h0);
    step(1, 1'b0, 4'h0, 6'h08, EI | LM, 1'b0, "fast_lda_t4");
    step(1, 1'b0, 4'h0, 6'h10, CE | LA, 1'b0, "fast_lda_t5");
    fetch(1, 4'h5);
    step(1, 1'b0, 4'h5, 6'h08, 12'h000, 1'b0, "fast_nop_t4");
    fetch(1, 4'h2);
    step(1, 1'b0, 4'h2, 6'h08, EI | LM, 1'b0, "fast_sub_t4");
    step(1, 1'b0, 4'h2, 6'h10, CE | LB, 1'b0, "fast_sub_t5");
    step(1, 1'b0, 4'h2, 6'h20, EU | LA | SU, 1'b0, "fast_sub_t6");
    step(1, 1'b0, 4'h2, 6'h01, EP | LM, 1'b0, "fast_wrap_t1");

    repeat (3) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain got %0d pending required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
